uart_tsr: RTL and testbench
===========================

# uart_tsr

UART transmit shift register. Sits downstream of the TX buffer stage and consumes the byte that stage presents on `tx_data`. It pops that stage with a one-cycle `tsr_load` pulse and serialises the byte onto `txd` as start / data / parity / stop bits. Bit timing comes from the shared 16x oversampling tick produced by the baud generator.

## Interface
Parameters:
- `OVERSAMPLE`, 16, `bclk_tick` pulses per bit period.

Ports (one clock; reset is asynchronous and active-high):
- `pclk` in 1: system clock.
- `preset` in 1: asynchronous, active-high reset.
- `bclk_tick` in 1: single-`pclk` pulse at 16x baud; may be high every cycle.
- `tx_data` in 8: byte at the head of the THR/TX FIFO; valid while `tx_data_valid`.
- `tx_data_valid` in 1: head byte available; `~tx_fifo_empty` in FIFO mode, THR-full in non-FIFO mode.
- `wls` in 2: word length; 00/01/10/11 = 5/6/7/8 bits.
- `stb` in 1: 0 = 1 stop bit; 1 = 2 stop bits, or 1.5 when `wls`=00.
- `pen` in 1: parity enable.
- `eps` in 1: even parity select.
- `sp` in 1: stick parity.
- `bc` in 1: break control; forces `txd` low.
- `txd` out 1: serial output; registered; idles high.
- `tsr_load` out 1: one-cycle pop/load strobe to the buffer stage.
- `tsr_empty` out 1: TEMT; high when no frame is in progress.

## Operation
- States: IDLE, START, DATA, PARITY, STOP (`tx_state_e`).
- **IDLE**
  - `txd`=1, `tsr_empty`=1.
  - `tsr_load = tx_data_valid & (state==IDLE | stop_last_tick) & ~preset`.
  - On `tsr_load`, latch `tx_data`, `wls`, `stb`, `pen`, `eps` and `sp` into the shift register and config shadows, then go to START.
  - LCR changes mid-frame take effect only at the next load.
- **START**
  - `txd`=0 for OVERSAMPLE ticks, then go to DATA.
- **DATA**
  - `txd`=shift[0], LSB first. Shift right every OVERSAMPLE ticks.
  - Bit counter runs 0..wls+4. After the last bit, go to PARITY if `pen`, else STOP.
- **PARITY**
  - sp=0: bit = XOR(data bits) ^ ~eps. Even parity gives XOR; odd parity gives inverted XOR.
  - sp=1: bit = ~eps.
  - Parity is computed over the latched word length only.
- **STOP**
  - `txd`=1 for 16 ticks (stb=0), 24 ticks (stb=1 and wls=00), or 32 ticks otherwise.
  - `stop_last_tick` is the final tick of STOP.
  - On `stop_last_tick` with `tx_data_valid`: pulse `tsr_load` and go directly to START, with no idle bit.
  - On `stop_last_tick` without `tx_data_valid`: go to IDLE.
- **Break**
  - `bc`=1 drives the `txd` register to 0 in every state.
  - The FSM and counters keep running, so frames are consumed silently.
  - `txd` returns to its FSM value on the cycle after `bc` falls.
- **Tick counter**
  - 5 bits. Cleared on entering each state; increments only on `bclk_tick`.
  - Width must hold a terminal count of 31 (2 stop bits).

## Timing
- Reset values:
  - state IDLE, `txd`=1, `tsr_empty`=1, `tsr_load`=0.
  - Shift register, counters and config shadows all 0.
- Reset mid-frame: `txd` goes to 1 asynchronously. No load occurs while `preset` is high.
- Load latency:
  - `tx_data_valid` rises at cycle N in IDLE → `tsr_load`=1 in cycle N.
  - At edge N+1: `txd`=0, `tsr_empty`=0.
  - `tsr_load` is never high for two consecutive cycles.
- Buffer handshake: the buffer pops on the edge where `tsr_load`=1. `tx_data` must be show-ahead, i.e. valid in the same cycle.
- Bit length:
  - Each bit ends on the OVERSAMPLE-th `bclk_tick` counted inside its state.
  - The start bit is therefore 15–16 tick periods plus less than one `pclk`.
  - Every later bit is exactly OVERSAMPLE ticks.
- `tsr_empty`:
  - Falls together with `txd` at the start bit.
  - Rises on the edge that enters IDLE.
  - Stays 0 across back-to-back frames.

## Structure
- `uart_pkg` holds:
  - `tx_state_e`.
  - OVERSAMPLE default.
  - WLS encoding constants.
  - Stop-tick constants STOP1=16, STOP1P5=24, STOP2=32.
- Single sub-module `uart_bit_timer`: tick counter with clear and terminal compare. The same block is to be reused by the receiver.
- Everything else is flat: FSM, shift register, parity accumulator.

## Test plan
- 8N1, 0xA5, `bclk_tick` every cycle:
  - `txd` = 0, 1,0,1,0,0,1,0,1, 1, each bit 16 cycles.
  - Exactly one `tsr_load`.
  - `tsr_empty` high again after the stop bit.
- 7E2, 0x35 and 7O1, 0x35:
  - 7E2: parity bit 0, stop bits 32 ticks.
  - 7O1: parity bit 1.
  - 5-bit, stb=1: stop bits 24 ticks.
- Stick parity, 8 bits, data 0x00 and 0xFF:
  - sp=1, eps=0 → parity 1.
  - sp=1, eps=1 → parity 0.
- Back-to-back, `tx_data_valid` held for 0x11 then 0x22:
  - Exactly two `tsr_load` pulses.
  - Second start bit immediately follows the first stop bit.
  - `tsr_empty` stays 0 throughout.
- Break and reset:
  - `bc`=1 during DATA → `txd`=0 next cycle; the FSM still reaches IDLE on schedule.
  - `preset` pulse mid-DATA → `txd`=1 immediately, IDLE, no spurious `tsr_load`.
  - LCR change mid-frame does not alter the current frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, oversampling default,
// word-length encodings and stop-bit durations in bclk ticks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int unsigned OVERSAMPLE_DEFAULT = 16;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    localparam int unsigned STOP1   = 16;
    localparam int unsigned STOP1P5 = 24;
    localparam int unsigned STOP2   = 32;

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick counter with synchronous clear; done flags the tick that
// reaches the terminal count. Shared by the UART transmitter and receiver.
module uart_bit_timer #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clr,
    input  logic [WIDTH-1:0] term,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign done = tick & (cnt_q == term);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tsr.sv
// UART transmit shift register: pops the TX buffer head with tsr_load and
// serialises start / data (LSB first) / optional parity / stop bits onto txd.
module uart_tsr
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       bclk_tick,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    input  logic       bc,
    output logic       txd,
    output logic       tsr_load,
    output logic       tsr_empty
);

    localparam logic [4:0] BIT_TERM = 5'(OVERSAMPLE - 1);

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       par_acc_q, par_acc_d;
    logic [1:0] wls_q, wls_d;
    logic       stb_q, stb_d;
    logic       pen_q, pen_d;
    logic       eps_q, eps_d;
    logic       sp_q, sp_d;
    logic       txd_q, txd_d;
    logic       tsr_empty_q, tsr_empty_d;

    logic       bit_done;
    logic       stop_last_tick;
    logic       last_bit;
    logic       par_bit;
    logic       txd_fsm;
    logic [4:0] stop_term;
    logic [4:0] term;

    always_comb begin
        stop_term = 5'(STOP1 - 1);
        if (stb_q) begin
            stop_term = (wls_q == WLS_5) ? 5'(STOP1P5 - 1) : 5'(STOP2 - 1);
        end
    end

    assign term = (state_q == STOP) ? stop_term : BIT_TERM;

    uart_bit_timer #(.WIDTH(5)) u_timer (
        .clk  (pclk),
        .rst  (preset),
        .tick (bclk_tick),
        .clr  ((state_q == IDLE) | bit_done),
        .term (term),
        .done (bit_done)
    );

    assign stop_last_tick = (state_q == STOP) & bit_done;
    assign last_bit       = (bit_cnt_q == ({1'b0, wls_q} + 3'd4));
    assign tsr_load       = tx_data_valid & ((state_q == IDLE) | stop_last_tick) & ~preset;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_acc_d = par_acc_q;
        wls_d     = wls_q;
        stb_d     = stb_q;
        pen_d     = pen_q;
        eps_d     = eps_q;
        sp_d      = sp_q;

        case (state_q)
            IDLE: ;
            START: if (bit_done) state_d = DATA;
            DATA: begin
                if (bit_done) begin
                    par_acc_d = par_acc_q ^ shift_q[0];
                    if (last_bit) begin
                        state_d = pen_q ? PARITY : STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            PARITY: if (bit_done) state_d = STOP;
            STOP: if (bit_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A load in STOP overrides the IDLE transition so the next start bit follows directly
        if (tsr_load) begin
            state_d   = START;
            shift_d   = tx_data;
            bit_cnt_d = '0;
            par_acc_d = 1'b0;
            wls_d     = wls;
            stb_d     = stb;
            pen_d     = pen;
            eps_d     = eps;
            sp_d      = sp;
        end

        par_bit = sp_q ? ~eps_q : (par_acc_d ^ ~eps_q);

        case (state_d)
            START:   txd_fsm = 1'b0;
            DATA:    txd_fsm = shift_d[0];
            PARITY:  txd_fsm = par_bit;
            default: txd_fsm = 1'b1;
        endcase

        txd_d       = bc ? 1'b0 : txd_fsm;
        tsr_empty_d = (state_d == IDLE);
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            par_acc_q   <= 1'b0;
            wls_q       <= '0;
            stb_q       <= 1'b0;
            pen_q       <= 1'b0;
            eps_q       <= 1'b0;
            sp_q        <= 1'b0;
            txd_q       <= 1'b1;
            tsr_empty_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            par_acc_q   <= par_acc_d;
            wls_q       <= wls_d;
            stb_q       <= stb_d;
            pen_q       <= pen_d;
            eps_q       <= eps_d;
            sp_q        <= sp_d;
            txd_q       <= txd_d;
            tsr_empty_q <= tsr_empty_d;
        end
    end

    assign txd       = txd_q;
    assign tsr_empty = tsr_empty_q;

endmodule

// File: tb/tb_uart_tsr.sv
// Self-checking bench for uart_tsr: table of frame configurations checked
// cycle by cycle against a scoreboard of expected serial frames.
module tb_uart_tsr;
    import uart_pkg::*;

    logic       pclk = 1'b0;
    logic       preset;
    logic       bclk_tick;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic [1:0] wls;
    logic       stb, pen, eps, sp, bc;
    logic       txd, tsr_load, tsr_empty;

    uart_tsr #(.OVERSAMPLE(16)) dut (
        .pclk          (pclk),
        .preset        (preset),
        .bclk_tick     (bclk_tick),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .wls           (wls),
        .stb           (stb),
        .pen           (pen),
        .eps           (eps),
        .sp            (sp),
        .bc            (bc),
        .txd           (txd),
        .tsr_load      (tsr_load),
        .tsr_empty     (tsr_empty)
    );

    always #5 pclk = ~pclk;

    int tick_div = 1;
    int tick_cnt = 0;
    initial begin
        bclk_tick = 1'b1;
        forever begin
            @(negedge pclk);
            tick_cnt++;
            bclk_tick = (tick_div == 1) || ((tick_cnt % tick_div) == 0);
        end
    end

    typedef struct {
        logic [7:0] data;
        logic [1:0] wls;
        logic       stb, pen, eps, sp;
        logic       exp_par;
        int         exp_stop;
    } vec_t;

    typedef struct {
        logic [11:0] seq;
        int          nseq;
        int          stop_cyc;
    } frame_t;

    frame_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic [1:0] w, input logic s,
                                input logic p, input logic e, input logic k,
                                input logic ep, input int es);
        vec_t v;
        v.data = d; v.wls = w; v.stb = s; v.pen = p; v.eps = e; v.sp = k;
        v.exp_par = ep; v.exp_stop = es;
        return v;
    endfunction

    function automatic void push_expected(input vec_t v);
        frame_t f;
        int nb;
        nb = int'(v.wls) + 5;
        f.seq = '1;
        f.seq[0] = 1'b0;
        for (int i = 0; i < nb; i++) f.seq[1 + i] = v.data[i];
        f.nseq = 1 + nb;
        if (v.pen) begin
            f.seq[f.nseq] = v.exp_par;
            f.nseq++;
        end
        f.stop_cyc = v.exp_stop;
        sb.push_back(f);
    endfunction

    // Called at a negedge in IDLE; returns at the negedge after the load edge.
    task automatic start_frame(input vec_t v, input logic hold);
        tx_data = v.data; wls = v.wls; stb = v.stb; pen = v.pen; eps = v.eps; sp = v.sp;
        tx_data_valid = 1'b1;
        push_expected(v);
        #1;
        chk("load_strobe", 32'(tsr_load), 32'd1);
        chk("empty_before_load", 32'(tsr_empty), 32'd1);
        @(negedge pclk);
        tx_data_valid = hold;
    endtask

    task automatic check_frame(input logic next_load, input int scramble_at,
                               input int bc_on, input int bc_off, input int rst_at);
        frame_t f;
        int t;
        logic exp_txd;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        f = sb.pop_front();
        t = 16 * f.nseq + f.stop_cyc;
        for (int i = 0; i < t; i++) begin
            if (i == rst_at) begin
                tx_data_valid = 1'b1;
                preset = 1'b1;
                #1;
                chk("rst_txd", 32'(txd), 32'd1);
                chk("rst_empty", 32'(tsr_empty), 32'd1);
                chk("rst_no_load", 32'(tsr_load), 32'd0);
                @(negedge pclk);
                chk("rst_hold_no_load", 32'(tsr_load), 32'd0);
                tx_data_valid = 1'b0;
                preset = 1'b0;
                @(negedge pclk);
                chk("post_rst_txd", 32'(txd), 32'd1);
                chk("post_rst_empty", 32'(tsr_empty), 32'd1);
                return;
            end
            if (i == scramble_at) begin
                wls = ~wls; pen = ~pen; stb = ~stb; eps = ~eps; sp = ~sp;
            end
            if (i == bc_on) bc = 1'b1;
            if (i == bc_off) bc = 1'b0;
            exp_txd = (i < 16 * f.nseq) ? f.seq[i / 16] : 1'b1;
            if (i > bc_on && i <= bc_off) exp_txd = 1'b0;
            chk("txd", 32'(txd), 32'(exp_txd));
            chk("tsr_empty_busy", 32'(tsr_empty), 32'd0);
            chk("tsr_load", 32'(tsr_load), (i == t - 1) ? 32'(next_load) : 32'd0);
            @(negedge pclk);
        end
        if (!next_load) begin
            chk("empty_after_stop", 32'(tsr_empty), 32'd1);
            chk("txd_idle", 32'(txd), 32'd1);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            chk("idle_txd", 32'(txd), 32'd1);
            chk("idle_no_load", 32'(tsr_load), 32'd0);
            @(negedge pclk);
        end
    endtask

    vec_t tbl[8];
    vec_t a5;

    initial begin
        int lo, tot;
        preset = 1'b1; tx_data = '0; tx_data_valid = 1'b0; wls = '0;
        stb = 0; pen = 0; eps = 0; sp = 0; bc = 0;

        tbl[0] = mk(8'hA5, 2'b11, 0, 0, 0, 0, 0, 16); // 8N1
        tbl[1] = mk(8'h35, 2'b10, 1, 1, 1, 0, 0, 32); // 7E2
        tbl[2] = mk(8'h35, 2'b10, 0, 1, 0, 0, 1, 16); // 7O1
        tbl[3] = mk(8'hFB, 2'b00, 1, 1, 1, 0, 0, 24); // 5E1.5, upper bits ignored
        tbl[4] = mk(8'h2C, 2'b01, 1, 1, 0, 0, 0, 32); // 6O2
        tbl[5] = mk(8'h00, 2'b11, 0, 1, 0, 1, 1, 16); // stick, eps=0
        tbl[6] = mk(8'hFF, 2'b11, 0, 1, 1, 1, 0, 16); // stick, eps=1
        tbl[7] = mk(8'h7F, 2'b11, 0, 1, 1, 0, 1, 16); // 8E1
        a5 = tbl[0];

        repeat (3) @(negedge pclk);
        chk("reset_txd", 32'(txd), 32'd1);
        chk("reset_empty", 32'(tsr_empty), 32'd1);
        chk("reset_load", 32'(tsr_load), 32'd0);
        tx_data_valid = 1'b1;
        #1;
        chk("reset_blocks_load", 32'(tsr_load), 32'd0);
        tx_data_valid = 1'b0;
        preset = 1'b0;
        @(negedge pclk);
        idle_cycles(3);

        for (int i = 0; i < 8; i++) begin
            start_frame(tbl[i], 1'b0);
            check_frame(1'b0, (i == 1) ? 40 : -1, -1, -1, -1);
            idle_cycles(2);
        end

        // Back-to-back: valid held, next byte presented after the first pop
        start_frame(mk(8'h11, 2'b11, 0, 0, 0, 0, 0, 16), 1'b1);
        tx_data = 8'h22;
        push_expected(mk(8'h22, 2'b11, 0, 0, 0, 0, 0, 16));
        check_frame(1'b1, -1, -1, -1, -1);
        tx_data_valid = 1'b0;
        check_frame(1'b0, -1, -1, -1, -1);
        idle_cycles(2);

        // Break during DATA
        start_frame(a5, 1'b0);
        check_frame(1'b0, -1, 40, 60, -1);
        idle_cycles(2);

        // Reset mid-DATA, then recovery
        start_frame(a5, 1'b0);
        check_frame(1'b0, -1, -1, -1, 50);
        idle_cycles(2);
        start_frame(a5, 1'b0);
        check_frame(1'b0, -1, -1, -1, -1);
        idle_cycles(2);

        // Tick every other cycle: start bit 31-32 cycles, later bits exactly 32
        tick_div = 2;
        start_frame(a5, 1'b0);
        void'(sb.pop_front());
        lo = 0;
        tot = -1;
        for (int i = 0; i < 1000; i++) begin
            if (tsr_empty) begin
                tot = i;
                break;
            end
            if (txd == 1'b0 && lo == i) lo++;
            @(negedge pclk);
        end
        chk("slow_start_len_ok", 32'(lo >= 31 && lo <= 32), 32'd1);
        chk("slow_frame_len", 32'(tot), 32'(lo + 9 * 32));
        tick_div = 1;
        idle_cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
